// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the
// data-memory access stage.
package mem_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/load_extend.sv
// load_extend: lane-select a loaded doubleword
// and sign/zero extend it to 64 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] sh;

  // shift the addressed lane down, then extend
  always_comb begin
    sh   = rdata >> {off, 3'b000};
    data = '0;
    unique case (funct3)
      F3_B:    data = {{56{sh[7]}}, sh[7:0]};
      F3_H:    data = {{48{sh[15]}}, sh[15:0]};
      F3_W:    data = {{32{sh[31]}}, sh[31:0]};
      F3_D:    data = sh;
      F3_BU:   data = {56'd0, sh[7:0]};
      F3_HU:   data = {48'd0, sh[15:0]};
      F3_WU:   data = {32'd0, sh[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: req/gnt/rvalid data-memory
// access with lane alignment and load extension.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ALUResult,
  input  logic [63:0] readData2,
  input  logic [2:0]  funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [63:0] wb_data,
  output logic        wb_fault
);

  state_t      state, state_n;
  logic [2:0]  off_q, off_n;
  logic [2:0]  f3_q, f3_n;
  logic        req_n, we_n;
  logic [63:0] addr_n, wd_n;
  logic [7:0]  be_n;
  logic        wbv_n, wbf_n;
  logic [63:0] wbd_n;

  logic [2:0]  off;
  logic [7:0]  be_c;
  logic        mis;
  logic        ill;
  logic        is_mem;
  logic        acc;
  logic [63:0] ext;

  assign ex_ready = (state == IDLE) & reset;
  assign acc      = ex_valid & ex_ready;
  assign off      = ALUResult[2:0];
  assign is_mem   = MemRead | MemWrite;

  load_extend u_ext (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext)
  );

  // size decode: byte lanes and misalignment
  always_comb begin
    mis  = 1'b0;
    be_c = 8'h00;
    unique case (1'b1)
      (funct3[1:0] == 2'd0): begin
        be_c = 8'h01 << off;
      end
      (funct3[1:0] == 2'd1): begin
        mis  = off[0];
        be_c = 8'h03 << off;
      end
      (funct3[1:0] == 2'd2): begin
        mis  = |off[1:0];
        be_c = 8'h0F << off;
      end
      default: begin
        mis  = |off;
        be_c = 8'hFF;
      end
    endcase
    // a load wins when both flags are set
    if (MemRead)
      ill = (funct3 == F3_ILL);
    else
      ill = funct3[2];
  end

  // next state and next registered outputs
  always_comb begin
    state_n = state;
    off_n   = off_q;
    f3_n    = f3_q;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    be_n    = mem_be;
    wd_n    = mem_wdata;
    wbv_n   = 1'b0;
    wbd_n   = wb_data;
    wbf_n   = wb_fault;
    unique case (state)
      IDLE: begin
        if (acc) begin
          off_n = off;
          f3_n  = funct3;
          wbd_n = '0;
          wbf_n = 1'b0;
          if (!is_mem) begin
            wbd_n   = ALUResult;
            wbv_n   = 1'b1;
            state_n = RESP;
          end else if (mis | ill) begin
            wbf_n   = 1'b1;
            wbv_n   = 1'b1;
            state_n = RESP;
          end else begin
            req_n   = 1'b1;
            we_n    = ~MemRead;
            addr_n  = {ALUResult[63:3], 3'b000};
            be_n    = be_c;
            wd_n    = MemRead ? '0 :
                      readData2 << {off, 3'b000};
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          req_n = 1'b0;
          if (mem_we) begin
            wbv_n   = 1'b1;
            state_n = RESP;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          wbd_n   = ext;
          wbv_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, capture and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      off_q     <= '0;
      f3_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_fault  <= 1'b0;
    end else begin
      state     <= state_n;
      off_q     <= off_n;
      f3_q      <= f3_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_be    <= be_n;
      mem_wdata <= wd_n;
      wb_valid  <= wbv_n;
      wb_data   <= wbd_n;
      wb_fault  <= wbf_n;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table plus
// stall and reset sequences for mem_access_stage.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ALUResult;
  logic [63:0] readData2;
  logic [2:0]  funct3;
  logic        MemRead;
  logic        MemWrite;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic        wb_fault;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ALUResult  (ALUResult),
    .readData2  (readData2),
    .funct3     (funct3),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_fault   (wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [63:0] rd2;
    logic [2:0]  f3;
    logic        mr;
    logic        mw;
    logic [63:0] rdata;
    logic        xreq;
    logic        xwe;
    logic [63:0] xaddr;
    logic [7:0]  xbe;
    logic [63:0] xwdata;
    logic [63:0] xwb;
    logic        xfault;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name,
                     input logic [143:0] act,
                     input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one op, play memory with gnt after gd
  // stall cycles and rvalid rd cycles after gnt
  task automatic do_op(input vec_t v,
                       input int gd,
                       input int rd,
                       input bit junk);
    int c, gcnt, gcyc, wbc, xlat;
    bit seen, bad;
    logic [63:0] gd_data;
    logic        gd_fault;
    chk({v.name, " ready"}, ex_ready, 1);
    ex_valid  = 1'b1;
    ALUResult = v.addr;
    readData2 = v.rd2;
    funct3    = v.f3;
    MemRead   = v.mr;
    MemWrite  = v.mw;
    tick();
    ex_valid  = 1'b0;
    c = 1; gcnt = 0; gcyc = 0; wbc = 0;
    seen = 0; bad = 0;
    gd_data = '0; gd_fault = 1'b0;
    while (wbc == 0 && c < 40) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (wb_valid) begin
        wbc      = c;
        gd_data  = wb_data;
        gd_fault = wb_fault;
      end else begin
        if (mem_req) begin
          seen = 1;
          if ({mem_we, mem_addr, mem_be, mem_wdata}
              !== {v.xwe, v.xaddr, v.xbe, v.xwdata})
            bad = 1;
          if (gcnt == gd) begin
            mem_gnt = 1'b1;
            gcyc    = c;
            if (junk && !v.xwe) begin
              mem_rvalid = 1'b1;
              mem_rdata  = ~v.rdata;
            end
          end else begin
            gcnt++;
          end
        end
        if (gcyc > 0 && !v.xwe && c == gcyc + rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
        end
        tick();
        c++;
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!v.xreq)     xlat = 1;
    else if (v.xwe)  xlat = gd + 2;
    else             xlat = gd + 2 + rd;
    chk({v.name, " req"}, seen, v.xreq);
    chk({v.name, " memfields"}, bad, 0);
    chk({v.name, " latency"}, wbc, xlat);
    chk({v.name, " wb_data"}, gd_data, v.xwb);
    chk({v.name, " wb_fault"}, gd_fault, v.xfault);
    tick();
    chk({v.name, " pulse"}, {wb_valid, ex_ready}, 2'b01);
  endtask

  initial begin
    bit wbseen;
    vec_t st;
    tbl[0]  = '{"pass", 64'h1234, 64'h0, 3'b000,
               1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
               8'h00, 64'h0, 64'h1234, 1'b0};
    tbl[1]  = '{"sb", 64'h1003, 64'hAB, 3'b000,
               1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 64'h1000,
               8'h08, 64'hAB00_0000, 64'h0, 1'b0};
    tbl[2]  = '{"lb", 64'h2006, 64'h0, 3'b000,
               1'b1, 1'b0, 64'h0080_0000_0000_0000,
               1'b1, 1'b0, 64'h2000, 8'h40, 64'h0,
               64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    tbl[3]  = '{"lbu", 64'h2006, 64'h0, 3'b100,
               1'b1, 1'b0, 64'h0080_0000_0000_0000,
               1'b1, 1'b0, 64'h2000, 8'h40, 64'h0,
               64'h80, 1'b0};
    tbl[4]  = '{"lw_mis", 64'h4002, 64'h0, 3'b010,
               1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
               8'h00, 64'h0, 64'h0, 1'b1};
    tbl[5]  = '{"st_ill", 64'h5000, 64'h55, 3'b100,
               1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 64'h0,
               8'h00, 64'h0, 64'h0, 1'b1};
    tbl[6]  = '{"sh", 64'h6006,
               64'h1122_3344_5566_BEEF, 3'b001,
               1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 64'h6000,
               8'hC0, 64'hBEEF_0000_0000_0000,
               64'h0, 1'b0};
    tbl[7]  = '{"lh", 64'h7002, 64'h0, 3'b001,
               1'b1, 1'b0, 64'h0000_0000_8001_0000,
               1'b1, 1'b0, 64'h7000, 8'h0C, 64'h0,
               64'hFFFF_FFFF_FFFF_8001, 1'b0};
    tbl[8]  = '{"lwu", 64'h8004, 64'h0, 3'b110,
               1'b1, 1'b0, 64'hF234_5678_0000_0000,
               1'b1, 1'b0, 64'h8000, 8'hF0, 64'h0,
               64'h0000_0000_F234_5678, 1'b0};
    tbl[9]  = '{"lw", 64'h8004, 64'h0, 3'b010,
               1'b1, 1'b0, 64'hF234_5678_0000_0000,
               1'b1, 1'b0, 64'h8000, 8'hF0, 64'h0,
               64'hFFFF_FFFF_F234_5678, 1'b0};
    tbl[10] = '{"sd", 64'h9000,
               64'hDEAD_BEEF_CAFE_F00D, 3'b011,
               1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 64'h9000,
               8'hFF, 64'hDEAD_BEEF_CAFE_F00D,
               64'h0, 1'b0};
    tbl[11] = '{"ld_mis", 64'hA004, 64'h0, 3'b011,
               1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
               8'h00, 64'h0, 64'h0, 1'b1};
    tbl[12] = '{"ld_ill", 64'hA000, 64'h0, 3'b111,
               1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
               8'h00, 64'h0, 64'h0, 1'b1};
    tbl[13] = '{"rw_both", 64'hB001, 64'h99, 3'b000,
               1'b1, 1'b1, 64'h7F00, 1'b1, 1'b0,
               64'hB000, 8'h02, 64'h0, 64'h7F, 1'b0};
    tbl[14] = '{"sw_mis", 64'hB006, 64'h1, 3'b010,
               1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 64'h0,
               8'h00, 64'h0, 64'h0, 1'b1};
    tbl[15] = '{"lhu", 64'hC006, 64'h0, 3'b101,
               1'b1, 1'b0, 64'hFFFE_0000_0000_0000,
               1'b1, 1'b0, 64'hC000, 8'hC0, 64'h0,
               64'hFFFE, 1'b0};

    reset      = 1'b0;
    ex_valid   = 1'b0;
    ALUResult  = '0;
    readData2  = '0;
    funct3     = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    chk("reset outs",
        {ex_ready, mem_req, mem_we, mem_addr, mem_be},
        '0);
    chk("reset outs2",
        {mem_wdata, wb_valid, wb_data, wb_fault}, '0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++)
      do_op(tbl[i], 0, 1, 1'b0);

    // gnt held off 3 cycles, rvalid 2 after gnt,
    // with a bogus rvalid alongside gnt
    st = '{"ld_stall", 64'h3000, 64'h0, 3'b011,
           1'b1, 1'b0, 64'h0123_4567_89AB_CDEF,
           1'b1, 1'b0, 64'h3000, 8'hFF, 64'h0,
           64'h0123_4567_89AB_CDEF, 1'b0};
    do_op(st, 3, 2, 1'b1);
    st = '{"sb_stall", 64'h3005, 64'h1C, 3'b000,
           1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 64'h3000,
           8'h20, 64'h1C00_0000_0000, 64'h0, 1'b0};
    do_op(st, 2, 1, 1'b0);

    // reset asserted while waiting for rvalid
    ex_valid  = 1'b1;
    ALUResult = 64'h3008;
    readData2 = '0;
    funct3    = 3'b011;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    tick();
    ex_valid = 1'b0;
    chk("rst req", {mem_req, mem_we}, 2'b10);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rst inwait", {mem_req, wb_valid}, 2'b00);
    reset = 1'b0;
    #1;
    chk("rst clear",
        {mem_req, mem_we, mem_addr, mem_be,
         mem_wdata, ex_ready}, '0);
    tick();
    reset = 1'b1;
    #1;
    chk("rst ready", ex_ready, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555;
    tick();
    mem_rvalid = 1'b0;
    wbseen = 0;
    for (int i = 0; i < 3; i++) begin
      if (wb_valid) wbseen = 1;
      tick();
    end
    chk("rst nowb", wbseen, 0);
    chk("rst idle", {ex_ready, mem_req}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage of the sequential RISC-V core, sitting after `ExecuteStage`. Takes the ALU result as the effective address and `readData2` as store data, then runs a req/gnt/rvalid transaction to data memory. Applies byte-lane alignment and load sign/zero extension, and returns one result to writeback. Non-memory instructions pass the ALU result through with one cycle of latency.

## Interface
Parameters: none; widths are fixed to RV64: XLEN=64, 8 byte lanes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute result valid
- ex_ready  out  1  stage can accept; high only in IDLE while reset is deasserted
- ALUResult  in  64  effective address, or pass-through result
- readData2  in  64  store data (low bytes used)
- funct3  in  3  access size/signedness
- MemRead  in  1  load
- MemWrite  in  1  store
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  64  doubleword-aligned address, {addr[63:3],3'b000}
- mem_be  out  8  byte enables
- mem_wdata  out  64  lane-shifted store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  load data valid
- mem_rdata  in  64  load data
- wb_valid  out  1  one-cycle result strobe
- wb_data  out  64  loaded or pass-through value
- wb_fault  out  1  misaligned or illegal access (qualified by wb_valid)

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- Accept condition: ex_valid & ex_ready in IDLE. Address, data, funct3 and the op flags are captured into registers.
- Neither MemRead nor MemWrite: wb_data = ALUResult; go to RESP.
- If both MemRead and MemWrite are set, the access is treated as a load.
- funct3 encodings: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
  - Stores with funct3[2]=1 are illegal.
- Misalignment: off = addr[2:0] must be a multiple of the access size.
  - Misaligned or illegal access: no memory request; go to RESP with wb_fault=1 and wb_data=0.
- Byte enables: B uses 8'h01<<off, H uses 8'h03<<off, W uses 8'h0F<<off, D uses 8'hFF.
- Store data: mem_wdata = readData2 << (8*off).
- Load data: (mem_rdata >> 8*off) truncated to the access size, then sign-extended (B/H/W) or zero-extended (BU/HU/WU).
- REQ: mem_req=1, with mem_we/addr/be/wdata held stable until mem_gnt.
  - Store with gnt: go to RESP.
  - Load with gnt: go to WAIT.
- WAIT: on mem_rvalid, capture the extended data into wb_data and go to RESP.
  - mem_rvalid outside WAIT is ignored.
- RESP: wb_valid=1 for exactly one cycle, then go to IDLE.
- Stores: wb_data=0, wb_fault=0.

## Timing
- All outputs except ex_ready are registered.
- Reset values: state IDLE; mem_req, mem_we, wb_valid and wb_fault are 0; mem_addr, mem_be, mem_wdata and wb_data are 0; ex_ready=0 while reset is low.
- Latencies, with acceptance in cycle N:
  - Pass-through or fault: wb_valid in N+1.
  - Store with gnt in N+1: wb_valid in N+2.
  - Load with gnt in N+1 and rvalid in N+k (k≥2): wb_valid in N+k+1.
- gnt stall: mem_req and all mem_* outputs stay unchanged each cycle gnt is low.
- mem_rvalid arriving in the same cycle as gnt is ignored; rvalid is required no earlier than the cycle after gnt.
- Back-to-back operation: ex_ready returns high in the cycle after RESP. Maximum throughput is one instruction per 2 cycles (pass-through).
- Reset asserted mid-transaction: outputs clear immediately and the FSM goes to IDLE. Any late rvalid is ignored.

## Structure
- Package mem_pkg holds the funct3 size constants (F3_B … F3_WU) and the state enum {IDLE, REQ, WAIT, RESP}.
- Sub-module load_extend is combinational: (rdata, off, funct3) → 64-bit extended value. It is instantiated once.
- The FSM, capture registers, byte-enable/wdata generation and misalignment check live in the top module.

## Test plan
- Pass-through: ALUResult=64'h1234, no mem op → wb_valid one cycle later, wb_data=64'h1234, mem_req never asserted.
- SB: addr=64'h1003, readData2=64'hAB, gnt immediate → mem_addr=64'h1000, mem_be=8'h08, mem_wdata[31:24]=8'hAB, wb_valid at N+2.
- LB sign/zero extension: addr=64'h2006, rdata=64'h0080_0000_0000_0000.
  - LB → wb_data=64'hFFFF_FFFF_FFFF_FF80.
  - LBU → wb_data=64'h80.
- Stalls: LD at addr=64'h3000 with gnt delayed 3 cycles and rvalid 2 cycles after gnt → mem_* outputs stable throughout, wb_data=rdata, single wb_valid pulse.
- Faults:
  - LW at addr=64'h4002 → no mem_req, wb_fault=1, wb_data=0 at N+1.
  - Store with funct3=100 → wb_fault=1.
- Reset during WAIT: reset low for 1 cycle, then rvalid pulse → no wb_valid, FSM in IDLE, ex_ready=1 after reset release.
